// File: rtl/instruction_loader_if.sv
// instruction_loader_if: byte-stream handshake and instruction-memory write port
//   byte_valid/byte_data/byte_ready : incoming byte stream, MSB of each word first
//   wr_en/wr_addr/wr_data           : one-cycle word write at a word index
//   master = loader side, slave = byte source / memory side
interface instruction_loader_if #(parameter int ADDR_WIDTH = 32);
  logic                  byte_valid;
  logic [7:0]            byte_data;
  logic                  byte_ready;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           wr_data;
  modport master(input byte_valid, byte_data, output byte_ready, wr_en, wr_addr, wr_data);
  modport slave(output byte_valid, byte_data, input byte_ready, wr_en, wr_addr, wr_data);
endinterface

// File: rtl/instruction_loader.sv
// instruction_loader: packs a byte stream into 32-bit words written at indices 0..NUM_WORDS-1
//   clk, reset_n : clock, synchronous active-low reset
//   start, abort : one-cycle pulses that begin / end a load
//   bus          : byte stream in, instruction-memory write port out
//   word_count   : words written in the current load
//   done, error  : load finished (held); aborted with a partial word (held)
module instruction_loader #(
  parameter int NUM_WORDS  = 3,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   abort,
  instruction_loader_if.master   bus,
  output logic [ADDR_WIDTH-1:0]  word_count,
  output logic                   done,
  output logic                   error
);
  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;
  state_t                state;
  logic [1:0]            byte_cnt;
  logic [31:0]           shift;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  accept;
  assign accept       = bus.byte_valid & bus.byte_ready;
  assign bus.wr_data  = shift;
  assign bus.wr_addr  = addr;
  // the write index and the count of written words always move together
  assign word_count   = addr;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      byte_cnt       <= '0;
      shift          <= '0;
      addr           <= '0;
      bus.byte_ready <= 1'b0;
      bus.wr_en      <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          state          <= LOAD;
          addr           <= '0;
          byte_cnt       <= '0;
          error          <= 1'b0;
          done           <= 1'b0;
          bus.byte_ready <= 1'b1;
        end
        LOAD: if (abort) begin
          // abort beats a simultaneous byte; a partial word is flagged, never written
          state          <= DONE;
          done           <= 1'b1;
          error          <= byte_cnt != 2'd0;
          bus.byte_ready <= 1'b0;
        end else if (accept) begin
          shift    <= {shift[23:0], bus.byte_data};
          byte_cnt <= byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            state          <= WRITE;
            bus.wr_en      <= 1'b1;
            bus.byte_ready <= 1'b0;
          end
        end
        WRITE: begin
          bus.wr_en <= 1'b0;
          addr      <= addr + 1'b1;
          byte_cnt  <= '0;
          if (addr == ADDR_WIDTH'(NUM_WORDS - 1)) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state          <= LOAD;
            bus.byte_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
